// File: rtl/const_materializer_if.sv
// Request/instruction handshake bundle for const_materializer.
// master = loader side driving requests and consuming words; slave = the materializer.
interface const_materializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    modport master (
        output in_valid, in_value, in_rt, out_ready,
        input  in_ready, out_valid, out_instr, out_last
    );

    modport slave (
        input  in_valid, in_value, in_rt, out_ready,
        output in_ready, out_valid, out_instr, out_last
    );
endinterface

// File: rtl/const_materializer.sv
// Rebuilds a 32-bit constant as ADDIU, LUI, or LUI+ORI into a destination register.
// Optional LUI_ONLY_OPT_EN: a non-fitting constant with a zero low half emits a lone LUI.
module const_materializer #(
    parameter logic [5:0] OP_ADDIU = 6'h09,
    parameter logic [5:0] OP_LUI   = 6'h0F,
    parameter logic [5:0] OP_ORI   = 6'h0D
) (
    input logic                  clock,
    input logic                  reset,
    const_materializer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT_HI,
        EMIT_LAST
    } state_t;

    state_t      state, next_state;
    logic [31:0] instr_p1;
    logic [31:0] ori_p1;
    logic        vld_p1;
    logic        accept;
    logic        fits;
    logic        single_word;
    logic        load_first;
    logic        load_ori;
    logic [31:0] first_word;
    logic [31:0] ori_word;

    // True when the value survives a round trip through a 16-bit sign-extended immediate.
    function automatic logic fits_imm16(input logic signed [31:0] v);
        return (v >= -32'sd32768) && (v <= 32'sd32767);
    endfunction

    function automatic logic [31:0] encode_i(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    assign fits       = fits_imm16($signed(bus.in_value));
    assign first_word = fits ? encode_i(OP_ADDIU, 5'd0, bus.in_rt, bus.in_value[15:0])
                             : encode_i(OP_LUI,   5'd0, bus.in_rt, bus.in_value[31:16]);
    assign ori_word   = encode_i(OP_ORI, bus.in_rt, bus.in_rt, bus.in_value[15:0]);

`ifdef LUI_ONLY_OPT_EN
    assign single_word = fits || (bus.in_value[15:0] == 16'h0000);
`else
    assign single_word = fits;
`endif

    // Ready depends on out_ready but never on in_valid.
    assign bus.in_ready = reset && ((state == IDLE) || ((state == EMIT_LAST) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        next_state = state;
        load_first = 1'b0;
        load_ori   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_first = 1'b1;
                    next_state = single_word ? EMIT_LAST : EMIT_HI;
                end
            end
            EMIT_HI: begin
                if (bus.out_ready) begin
                    load_ori   = 1'b1;
                    next_state = EMIT_LAST;
                end
            end
            EMIT_LAST: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        load_first = 1'b1;
                        next_state = single_word ? EMIT_LAST : EMIT_HI;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage p1: registered output word and sequence state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            instr_p1 <= 32'h0;
        end else begin
            state <= next_state;
            if (load_first) begin
                instr_p1 <= first_word;
            end else if (load_ori) begin
                instr_p1 <= ori_p1;
            end
        end
    end

    // The ORI word is only ever read after EMIT_HI, so it needs no reset.
    always_ff @(posedge clock) begin
        if (load_first) begin
            ori_p1 <= ori_word;
        end
    end

    assign vld_p1        = (state != IDLE);
    assign bus.out_valid = vld_p1;
    assign bus.out_last  = (state == EMIT_LAST);
    assign bus.out_instr = instr_p1;

endmodule
